k2_program_loader: RTL and testbench

K2_PROGRAM_LOADER -- requirements
Module: k2_program_loader

---
 rtl/k2_pkg.sv | 21 ++
 rtl/k2_program_loader_if.sv | 28 ++
 rtl/k2_prog_ram.sv | 50 +++++
 rtl/k2_program_loader.sv | 117 +++++++++++
 tb/tb_k2_program_loader.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/k2_pkg.sv
// Shared definitions for the K2 program loader: FSM states and default sizing.
package k2_pkg;

  // Default program memory depth and the address width that covers it.
  localparam int PROG_DEPTH = 16;
  localparam int ADDR_W_DEF = $clog2(PROG_DEPTH);
  localparam int BITS_DEF   = 8;

  // Loader control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // True when an accepted byte finishes the burst: explicit last marker or top entry reached.
  function automatic logic burst_ends(input logic accept, input logic last, input logic at_top);
    return accept && (last || at_top);
  endfunction

endpackage

// File: rtl/k2_program_loader_if.sv
// Byte-load handshake and instruction fetch bus between the loader and its neighbours.
interface k2_program_loader_if
  import k2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int Bits   = BITS_DEF
);

  logic              wr_valid;
  logic [Bits-1:0]   wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic [ADDR_W-1:0] ProgramAddress;
  logic [Bits-1:0]   instruction_data;

  // Host/processor side: drives bytes and fetch address, receives ready and instructions.
  modport master (
    output wr_valid, wr_data, wr_last, ProgramAddress,
    input  wr_ready, instruction_data
  );

  // Loader side.
  modport slave (
    input  wr_valid, wr_data, wr_last, ProgramAddress,
    output wr_ready, instruction_data
  );

endinterface

// File: rtl/k2_prog_ram.sv
// Program storage: one synchronous write port, one asynchronous read port,
// and an asynchronous clear of every entry on reset.
module k2_prog_ram
  import k2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int Bits   = BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [Bits-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [Bits-1:0]   rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [Bits-1:0] mem_q [DEPTH];
  logic [Bits-1:0] mem_d [DEPTH];

  // Next memory image: untouched entries keep their contents, only the addressed one updates.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d[waddr] = mem_q[waddr];
    end
  end

  // Storage flops, cleared to zero by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/k2_program_loader.sv
// Program loader: accepts a byte burst into program memory while holding the
// processor in reset, then releases it and serves instruction fetches.
module k2_program_loader
  import k2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int Bits   = BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  k2_program_loader_if.slave   bus,
  output logic                 cpu_rst_n,
  output logic                 loading,
  output logic                 load_done
);

  // Pointer is one bit wider than the address so it never wraps back onto entry 0.
  localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic            wr_ready_q, wr_ready_d;
  logic            loading_q, loading_d;
  logic            load_done_q, load_done_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;

  logic            accept;
  logic            at_top;
  logic [Bits-1:0] rd_data;

  assign accept = bus.wr_valid && wr_ready_q;
  assign at_top = (wr_ptr_q == LAST_PTR);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load_start is deliberately not looked at while in LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_start) state_d = LOAD;
        else            state_d = IDLE;
      end
      LOAD: begin
        if (burst_ends(accept, bus.wr_last, at_top)) state_d = RUN;
        else                                          state_d = LOAD;
      end
      RUN: begin
        if (load_start) state_d = LOAD;
        else            state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and pointer next values, all derived from the upcoming state so they register in step with it.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if ((state_q != LOAD) && (state_d == LOAD)) begin
      wr_ptr_d = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    wr_ready_d  = (state_d == LOAD);
    loading_d   = (state_d == LOAD);
    cpu_rst_n_d = (state_d == RUN);
    load_done_d = (state_q == LOAD) && (state_d == RUN);
  end

  // Registered pointer and control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      wr_ready_q  <= 1'b0;
      loading_q   <= 1'b0;
      load_done_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_ready_q  <= wr_ready_d;
      loading_q   <= loading_d;
      load_done_q <= load_done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  k2_prog_ram #(
    .ADDR_W (ADDR_W),
    .Bits   (Bits)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (bus.wr_data),
    .raddr (bus.ProgramAddress),
    .rdata (rd_data)
  );

  assign bus.wr_ready         = wr_ready_q;
  assign bus.instruction_data = (state_q == RUN) ? rd_data : '0;
  assign cpu_rst_n            = cpu_rst_n_q;
  assign loading              = loading_q;
  assign load_done            = load_done_q;

endmodule

// File: tb/tb_k2_program_loader.sv
// Directed self-checking bench for k2_program_loader.
module tb_k2_program_loader;
  import k2_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic load_start;
  logic cpu_rst_n;
  logic loading;
  logic load_done;

  int checks = 0;
  int errors = 0;

  k2_program_loader_if #(.ADDR_W(4), .Bits(8)) bus ();

  k2_program_loader #(.ADDR_W(4), .Bits(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .bus        (bus),
    .cpu_rst_n  (cpu_rst_n),
    .loading    (loading),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.ProgramAddress = a;
    #1;
    chk8(tag, bus.instruction_data, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    tick();
  endtask

  task automatic idle_bus();
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.wr_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    load_start = 1'b0;
    idle_bus();
    bus.ProgramAddress = 4'd0;

    // Reset state
    #3;
    chk1("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk1("rst_wr_ready", bus.wr_ready, 1'b0);
    chk1("rst_loading", loading, 1'b0);
    chk1("rst_load_done", load_done, 1'b0);
    #9;
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 8'h00, "rst_instr");
    end

    // Full 16-byte load
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk1("full_loading", loading, 1'b1);
    chk1("full_wr_ready", bus.wr_ready, 1'b1);
    chk1("full_cpu_held", cpu_rst_n, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(8'h10 + 8'(i), 1'b0);
      if (i < 15) begin
        chk1("full_no_early_done", load_done, 1'b0);
      end
    end
    idle_bus();
    chk1("full_load_done", load_done, 1'b1);
    chk1("full_cpu_run", cpu_rst_n, 1'b1);
    chk1("full_ready_low", bus.wr_ready, 1'b0);
    chk1("full_loading_low", loading, 1'b0);
    rd(4'd5, 8'h15, "full_addr5");
    rd(4'd0, 8'h10, "full_addr0");
    rd(4'd15, 8'h1F, "full_addr15");
    tick();
    chk1("full_done_pulse", load_done, 1'b0);
    rd(4'd5, 8'h15, "full_addr5_again");

    // Reload from RUN, short burst with a repeated load_start ignored mid-burst
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk1("reload_cpu_held", cpu_rst_n, 1'b0);
    chk1("reload_loading", loading, 1'b1);
    rd(4'd5, 8'h00, "reload_instr_zero");
    send(8'hA1, 1'b0);
    load_start = 1'b1;
    send(8'hA2, 1'b0);
    load_start = 1'b0;
    chk1("short_still_loading", loading, 1'b1);
    send(8'hA3, 1'b1);
    idle_bus();
    chk1("short_load_done", load_done, 1'b1);
    chk1("short_cpu_run", cpu_rst_n, 1'b1);
    rd(4'd0, 8'hA1, "short_addr0");
    rd(4'd1, 8'hA2, "short_addr1");
    rd(4'd2, 8'hA3, "short_addr2");
    rd(4'd3, 8'h13, "short_addr3_kept");
    rd(4'd15, 8'h1F, "short_addr15_kept");

    // wr_valid while in RUN must not write
    send(8'hFF, 1'b1);
    idle_bus();
    tick();
    rd(4'd3, 8'h13, "run_write_ignored3");
    rd(4'd0, 8'hA1, "run_write_ignored0");

    // Gapped valid burst
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send(8'hB0, 1'b0);
    bus.wr_valid = 1'b0; bus.wr_data = 8'hEE; bus.wr_last = 1'b1;
    tick();
    chk1("gap_still_loading", loading, 1'b1);
    chk1("gap_no_done", load_done, 1'b0);
    send(8'hB1, 1'b0);
    bus.wr_valid = 1'b0; bus.wr_data = 8'hEE; bus.wr_last = 1'b1;
    tick();
    chk1("gap_still_loading2", loading, 1'b1);
    send(8'hB2, 1'b1);
    idle_bus();
    chk1("gap_load_done", load_done, 1'b1);
    rd(4'd0, 8'hB0, "gap_addr0");
    rd(4'd1, 8'hB1, "gap_addr1");
    rd(4'd2, 8'hB2, "gap_addr2");
    rd(4'd3, 8'h13, "gap_addr3_kept");

    // Reset in the middle of a burst
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    idle_bus();
    #2;
    rst = 1'b1;
    #1;
    chk1("midrst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk1("midrst_wr_ready", bus.wr_ready, 1'b0);
    chk1("midrst_loading", loading, 1'b0);
    chk1("midrst_load_done", load_done, 1'b0);
    #3;
    rst = 1'b0;
    tick();
    chk1("midrst_idle", loading, 1'b0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send(8'hD0, 1'b1);
    idle_bus();
    chk1("postrst_done", load_done, 1'b1);
    rd(4'd0, 8'hD0, "postrst_addr0");
    rd(4'd1, 8'h00, "postrst_addr1_cleared");
    rd(4'd3, 8'h00, "postrst_addr3_cleared");
    rd(4'd15, 8'h00, "postrst_addr15_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
